// File: rtl/fsim_channel_arbiter_pkg.sv
// Shared types and constants for the FSim channel arbiter slice.
package fsim_arb_pkg;

  localparam int FSIM_N_CLIENTS = 4;
  localparam int FSIM_REQ_BITS  = 32;
  localparam int FSIM_RESP_BITS = 32;

  typedef logic [$clog2(FSIM_N_CLIENTS)-1:0] client_id_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fsim_channel_arbiter_if.sv
// Client-side and manager-side handshake bundle of the FSim channel arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface fsim_channel_arbiter_if
  import fsim_arb_pkg::*;
#(
  parameter int N_CLIENTS = FSIM_N_CLIENTS,
  parameter int REQ_BITS  = FSIM_REQ_BITS,
  parameter int RESP_BITS = FSIM_RESP_BITS
);

  logic [N_CLIENTS-1:0]          cl_req_valid;
  logic [N_CLIENTS-1:0]          cl_req_ready;
  logic [N_CLIENTS*REQ_BITS-1:0] cl_req_bits;
  logic [N_CLIENTS-1:0]          cl_resp_valid;
  logic [N_CLIENTS-1:0]          cl_resp_ready;
  logic [RESP_BITS-1:0]          cl_resp_bits;
  logic                          fsim_req_valid;
  logic                          fsim_req_ready;
  logic [REQ_BITS-1:0]           fsim_req_bits;
  logic                          fsim_resp_valid;
  logic                          fsim_resp_ready;
  logic [RESP_BITS-1:0]          fsim_resp_bits;

  modport slave (
    input  cl_req_valid, cl_req_bits, cl_resp_ready,
    input  fsim_req_ready, fsim_resp_valid, fsim_resp_bits,
    output cl_req_ready, cl_resp_valid, cl_resp_bits,
    output fsim_req_valid, fsim_req_bits, fsim_resp_ready
  );

  modport master (
    output cl_req_valid, cl_req_bits, cl_resp_ready,
    output fsim_req_ready, fsim_resp_valid, fsim_resp_bits,
    input  cl_req_ready, cl_resp_valid, cl_resp_bits,
    input  fsim_req_valid, fsim_req_bits, fsim_resp_ready
  );

endinterface

// File: rtl/fsim_channel_arbiter_id_fifo.sv
// FIFO of client IDs recording which client each in-flight request belongs to.
// A push is accepted when not full, or when a pop happens in the same cycle.
module fsim_id_fifo
  import fsim_arb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type id_t  = client_id_t
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  id_t                      push_id,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output id_t                      head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(DEPTH);

  id_t              mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (count_r == {(PTR_W+1){1'b0}});
  assign full      = (count_r == DEPTH_C);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);

  // Storage, wrapping pointers and occupancy; push+pop together leaves occupancy unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_id;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      if (push_ok_s && !pop_ok_s) begin
        count_r <= count_r + 1'b1;
      end else if (!push_ok_s && pop_ok_s) begin
        count_r <= count_r - 1'b1;
      end else begin
        count_r <= count_r;
      end
    end
  end

endmodule

// File: rtl/fsim_channel_arbiter.sv
// Shares one FSim manager request/response channel among N_CLIENTS requesters.
// Requests are granted round-robin and forwarded one at a time; responses come back
// in request order and are routed by the client ID recorded at capture time.
module fsim_channel_arbiter
  import fsim_arb_pkg::*;
#(
  parameter int N_CLIENTS       = FSIM_N_CLIENTS,
  parameter int REQ_BITS        = FSIM_REQ_BITS,
  parameter int RESP_BITS       = FSIM_RESP_BITS,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  fsim_channel_arbiter_if.slave              bus,
  output logic                               err_orphan_resp,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

  localparam int ID_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  typedef logic [ID_W-1:0] cid_t;

  arb_state_e          state_r;
  arb_state_e          state_nxt_s;
  cid_t                rr_ptr_r;
  cid_t                rr_nxt_s;
  logic [REQ_BITS-1:0] req_bits_r;
  logic                err_r;
  logic [ID_W:0]       pick_s;
  logic                pick_found_s;
  cid_t                win_id_s;
  logic [REQ_BITS-1:0] win_bits_s;
  logic                capture_s;
  logic                pop_s;
  logic                orphan_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  cid_t                fifo_head_s;

  // First requester at or after ptr, wrapping; returns {found, id}.
  function automatic logic [ID_W:0] rr_pick(input logic [N_CLIENTS-1:0] valid,
                                            input cid_t ptr);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    // Walk offsets from farthest to nearest so the nearest valid client is kept last.
    for (int k = N_CLIENTS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_CLIENTS;
      if (valid[idx]) begin
        res = {1'b1, cid_t'(idx)};
      end
    end
    return res;
  endfunction

  assign pick_s       = rr_pick(bus.cl_req_valid, rr_ptr_r);
  assign pick_found_s = pick_s[ID_W];
  assign win_id_s     = pick_s[ID_W-1:0];
  assign win_bits_s   = bus.cl_req_bits[int'(win_id_s)*REQ_BITS +: REQ_BITS];
  assign rr_nxt_s     = cid_t'((int'(win_id_s) + 1) % N_CLIENTS);

  fsim_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .id_t  (cid_t)
  ) u_id_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (capture_s),
    .push_id (win_id_s),
    .pop     (pop_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .head    (fifo_head_s),
    .count   (outstanding)
  );

  // Request FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request FSM next state, capture decision and one-hot client ready.
  always_comb begin
    state_nxt_s      = state_r;
    capture_s        = 1'b0;
    bus.cl_req_ready = '0;
    case (state_r)
      IDLE: begin
        // A full FIFO can still accept when the head is being answered this cycle.
        if (!reset && pick_found_s && (!fifo_full_s || pop_s)) begin
          capture_s                  = 1'b1;
          bus.cl_req_ready[win_id_s] = 1'b1;
          state_nxt_s                = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (bus.fsim_req_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Captured payload, round-robin pointer and sticky orphan flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_r   <= '0;
      req_bits_r <= '0;
      err_r      <= 1'b0;
    end else begin
      if (capture_s) begin
        rr_ptr_r   <= rr_nxt_s;
        req_bits_r <= win_bits_s;
      end
      if (orphan_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Response routing to the client at the FIFO head; with no owner the response is dropped.
  always_comb begin
    bus.cl_resp_valid   = '0;
    bus.fsim_resp_ready = 1'b0;
    pop_s               = 1'b0;
    orphan_s            = 1'b0;
    if (reset) begin
      pop_s = 1'b0;
    end else if (!fifo_empty_s) begin
      bus.cl_resp_valid[fifo_head_s] = bus.fsim_resp_valid;
      bus.fsim_resp_ready            = bus.cl_resp_ready[fifo_head_s];
      pop_s = bus.fsim_resp_valid & bus.cl_resp_ready[fifo_head_s];
    end else begin
      bus.fsim_resp_ready = 1'b1;
      orphan_s            = bus.fsim_resp_valid;
    end
  end

  assign bus.cl_resp_bits   = reset ? {RESP_BITS{1'b0}} : bus.fsim_resp_bits;
  assign bus.fsim_req_valid = (state_r == SEND);
  assign bus.fsim_req_bits  = req_bits_r;
  assign err_orphan_resp    = err_r;

endmodule

// File: tb/tb_fsim_channel_arbiter.sv
// Directed and randomized bench for fsim_channel_arbiter with a transaction-level model:
// a queue of owner IDs, a round-robin pointer and a single in-flight request slot.
module tb_fsim_channel_arbiter;
  import fsim_arb_pkg::*;

  localparam int N = 4;
  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       err;
  logic [2:0] outst;

  always #5 clock = ~clock;

  fsim_channel_arbiter_if #(.N_CLIENTS(N), .REQ_BITS(32), .RESP_BITS(32)) bus ();

  fsim_channel_arbiter #(
    .N_CLIENTS(N), .REQ_BITS(32), .RESP_BITS(32), .MAX_OUTSTANDING(D)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (bus.slave),
    .err_orphan_resp (err),
    .outstanding     (outst)
  );

  int          checks   = 0;
  int          failures = 0;
  bit          m_busy;
  logic [31:0] m_payload;
  int          m_rr;
  int          m_q[$];
  bit          m_orphan;
  int          m_sent;
  int          gq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_payload = 32'h0; m_rr = 0; m_q.delete(); m_orphan = 1'b0; m_sent = 0;
  endtask

  // One clock: predict and compare every output, advance, then update the model.
  task automatic cycle();
    int          w;
    bit          found;
    bit          pop;
    bit          cap;
    int          head;
    logic [N-1:0] e_rr;
    logic [N-1:0] e_rv;
    logic        e_frr;
    logic [31:0] cap_bits;
    #1;
    found = 1'b0; w = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && bus.cl_req_valid[(m_rr + k) % N]) begin
        found = 1'b1; w = (m_rr + k) % N;
      end
    end
    e_rv = '0;
    if (m_q.size() > 0) begin
      head  = m_q[0];
      e_rv[head] = bus.fsim_resp_valid;
      e_frr = bus.cl_resp_ready[head];
      pop   = bus.fsim_resp_valid && bus.cl_resp_ready[head];
    end else begin
      e_frr = 1'b1;
      pop   = 1'b0;
    end
    cap  = !m_busy && found && (m_q.size() < D || pop);
    e_rr = '0;
    if (cap) e_rr[w] = 1'b1;
    cap_bits = bus.cl_req_bits[w*32 +: 32];
    chk("cl_req_ready",    64'(bus.cl_req_ready),    64'(e_rr));
    chk("cl_resp_valid",   64'(bus.cl_resp_valid),   64'(e_rv));
    chk("cl_resp_bits",    64'(bus.cl_resp_bits),    64'(bus.fsim_resp_bits));
    chk("fsim_resp_ready", 64'(bus.fsim_resp_ready), 64'(e_frr));
    chk("fsim_req_valid",  64'(bus.fsim_req_valid),  64'(m_busy));
    chk("fsim_req_bits",   64'(bus.fsim_req_bits),   64'(m_payload));
    chk("outstanding",     64'(outst),               64'(m_q.size()));
    chk("err_orphan",      64'(err),                 64'(m_orphan));
    for (int i = 0; i < N; i++) if (bus.cl_req_ready[i]) gq.push_back(i);
    @(posedge clock);
    if (m_q.size() == 0 && bus.fsim_resp_valid) m_orphan = 1'b1;
    if (m_busy && bus.fsim_req_ready) begin m_busy = 1'b0; m_sent++; end
    if (pop) begin void'(m_q.pop_front()); m_sent--; end
    if (cap) begin
      m_q.push_back(w); m_payload = cap_bits; m_rr = (w + 1) % N; m_busy = 1'b1;
    end
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int g;
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 0, 1};
    // Reset with every input active: all outputs must be zero.
    reset = 1'b1;
    bus.cl_req_valid = 4'hF; bus.cl_req_bits = '1; bus.cl_resp_ready = 4'hF;
    bus.fsim_req_ready = 1'b1; bus.fsim_resp_valid = 1'b1; bus.fsim_resp_bits = 32'hFFFF_FFFF;
    #7;
    chk("rst_req_ready",  64'(bus.cl_req_ready),    64'h0);
    chk("rst_resp_valid", 64'(bus.cl_resp_valid),   64'h0);
    chk("rst_resp_ready", 64'(bus.fsim_resp_ready), 64'h0);
    chk("rst_req_valid",  64'(bus.fsim_req_valid),  64'h0);
    chk("rst_req_bits",   64'(bus.fsim_req_bits),   64'h0);
    chk("rst_outst",      64'(outst),               64'h0);
    chk("rst_err",        64'(err),                 64'h0);
    bus.cl_req_valid = 4'h0; bus.fsim_resp_valid = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    cycle();

    // Single client 2, payload forwarded one cycle after its handshake.
    bus.cl_req_valid = 4'b0100; bus.cl_req_bits[2*32 +: 32] = 32'hDEAD_BEEF;
    #1;
    chk("t1_grant", 64'(bus.cl_req_ready), 64'h4);
    chk("t1_novalid_yet", 64'(bus.fsim_req_valid), 64'h0);
    cycle();
    bus.cl_req_valid = 4'b0000;
    chk("t1_req_valid", 64'(bus.fsim_req_valid), 64'h1);
    chk("t1_req_bits",  64'(bus.fsim_req_bits),  64'hDEAD_BEEF);
    cycle();
    bus.fsim_resp_valid = 1'b1; bus.fsim_resp_bits = 32'h0000_1234;
    #1;
    chk("t1_resp_valid", 64'(bus.cl_resp_valid), 64'h4);
    chk("t1_resp_bits",  64'(bus.cl_resp_bits),  64'h1234);
    cycle();
    bus.fsim_resp_valid = 1'b0;
    chk("t1_outst", 64'(outst), 64'h0);

    // Fairness: all clients always valid, manager answers every sent request.
    reset_dut();
    gq.delete();
    bus.cl_req_valid = 4'hF;
    for (int c = 0; c < 14; c++) begin
      bus.fsim_resp_valid = (m_sent > 0);
      bus.fsim_resp_bits  = $urandom;
      cycle();
    end
    bus.fsim_resp_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      g = (k < gq.size()) ? gq[k] : -1;
      chk("t2_grant_order", 64'(g), 64'(exp_order[k]));
    end

    // Backpressure: no responses, capture stops at FIFO depth.
    reset_dut();
    gq.delete();
    bus.cl_req_valid = 4'hF;
    for (int c = 0; c < 12; c++) cycle();
    chk("t3_captures", 64'(gq.size()), 64'(D));
    chk("t3_outst", 64'(outst), 64'(D));
    #1;
    chk("t3_ready_zero", 64'(bus.cl_req_ready), 64'h0);
    bus.fsim_resp_valid = 1'b1; bus.fsim_resp_bits = $urandom;
    #1;
    chk("t3_release_same_cycle", 64'(bus.cl_req_ready != 4'h0), 64'h1);
    cycle();
    bus.fsim_resp_valid = 1'b0;
    chk("t3_outst_held", 64'(outst), 64'(D));

    // Response stall: head is client 1, only client 3 ready.
    reset_dut();
    bus.cl_req_valid = 4'b0010; cycle();
    bus.cl_req_valid = 4'b0000; cycle();
    bus.cl_req_valid = 4'b1000; cycle();
    bus.cl_req_valid = 4'b0000; cycle();
    bus.cl_resp_ready = 4'b1000; bus.fsim_resp_valid = 1'b1; bus.fsim_resp_bits = 32'hA5A5_0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4_resp_ready", 64'(bus.fsim_resp_ready), 64'h0);
      chk("t4_resp_valid", 64'(bus.cl_resp_valid), 64'h2);
      cycle();
      chk("t4_no_pop", 64'(outst), 64'h2);
    end
    bus.cl_resp_ready = 4'hF;
    cycle();
    chk("t4_pop", 64'(outst), 64'h1);
    cycle();
    bus.fsim_resp_valid = 1'b0;
    chk("t4_drained", 64'(outst), 64'h0);

    // Orphan response with the FIFO empty.
    bus.fsim_resp_valid = 1'b1;
    #1;
    chk("t5_resp_ready", 64'(bus.fsim_resp_ready), 64'h1);
    chk("t5_no_valid", 64'(bus.cl_resp_valid), 64'h0);
    cycle();
    bus.fsim_resp_valid = 1'b0;
    chk("t5_err_set", 64'(err), 64'h1);
    for (int c = 0; c < 10; c++) cycle();
    chk("t5_err_sticky", 64'(err), 64'h1);

    // Async reset while in SEND with two outstanding.
    reset_dut();
    bus.cl_req_valid = 4'hF;
    cycle(); cycle(); cycle();
    bus.fsim_req_ready = 1'b0;
    cycle();
    chk("t6_pre_outst", 64'(outst), 64'h2);
    chk("t6_pre_send", 64'(bus.fsim_req_valid), 64'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_req_valid", 64'(bus.fsim_req_valid), 64'h0);
    chk("t6_req_bits",  64'(bus.fsim_req_bits),  64'h0);
    chk("t6_req_ready", 64'(bus.cl_req_ready),   64'h0);
    chk("t6_outst",     64'(outst),              64'h0);
    chk("t6_err",       64'(err),                64'h0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.fsim_req_ready = 1'b1;
    #1;
    chk("t6_first_grant", 64'(bus.cl_req_ready), 64'h1);
    cycle();

    // Randomized traffic against the model.
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      bus.cl_req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) bus.cl_req_bits[i*32 +: 32] = $urandom;
      bus.cl_resp_ready   = 4'($urandom_range(0, 15));
      bus.fsim_req_ready  = 1'($urandom_range(0, 1));
      bus.fsim_resp_valid = (m_sent > 0) && ($urandom_range(0, 2) != 0);
      bus.fsim_resp_bits  = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
